// File: rtl/fibo_req_sched.sv
// fibo_req_sched
// Request scheduler wrapped around a single fibo_fun HLS core.
// Accepts one request at a time, launches the core with ap_start,
// waits for ap_done, and returns the result with the caller tag.
// A watchdog turns a hung core into an error response (data 0, err 1).
//
// Ports
//   ap_clk, ap_rst          clock, asynchronous active-high reset
//   req_valid/req_ready     request handshake; req_n index, req_tag caller tag
//   core_start, core_n      ap_start / n towards the core
//   core_ready, core_done   ap_ready / ap_done from the core
//   core_return             ap_return, valid while core_done is high
//   rsp_valid/rsp_ready     response handshake; rsp_data, rsp_tag, rsp_err
//   ok_cnt                  good responses delivered (wrapping)
//   err_cnt                 timeout responses delivered (saturating)
module fibo_req_sched #(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_n,
  input  logic [TAG_W-1:0] req_tag,
  output logic             core_start,
  output logic [31:0]      core_n,
  input  logic             core_ready,
  input  logic             core_done,
  input  logic [31:0]      core_return,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic [15:0]      ok_cnt,
  output logic [7:0]       err_cnt
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [31:0]       coreN_q, coreN_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [31:0]       rspData_q, rspData_d;
  logic [TAG_W-1:0]  rspTag_q, rspTag_d;
  logic              rspErr_q, rspErr_d;
  logic [15:0]       okCnt_q, okCnt_d;
  logic [7:0]        errCnt_q, errCnt_d;
  logic              rdyEn_q;
  logic              capture;

  // rdyEn_q keeps req_ready low until the first clock edge after reset
  // is released, so the request port never opens asynchronously.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q   <= IDLE;
      wd_q      <= '0;
      coreN_q   <= '0;
      tag_q     <= '0;
      rspData_q <= '0;
      rspTag_q  <= '0;
      rspErr_q  <= 1'b0;
      okCnt_q   <= '0;
      errCnt_q  <= '0;
      rdyEn_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      coreN_q   <= coreN_d;
      tag_q     <= tag_d;
      rspData_q <= rspData_d;
      rspTag_q  <= rspTag_d;
      rspErr_q  <= rspErr_d;
      okCnt_q   <= okCnt_d;
      errCnt_q  <= errCnt_d;
      rdyEn_q   <= 1'b1;
    end
  end

  // In ISSUE the core may only finish together with accepting the start
  // (ap_ready); in WAIT any ap_done completes the job.
  assign capture = core_done && ((state_q == WAIT) || core_ready);

  // Next-state logic. A core result beats watchdog expiry in the same cycle.
  // core_done/core_ready are not looked at in IDLE or RESP.
  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    coreN_d   = coreN_q;
    tag_d     = tag_q;
    rspData_d = rspData_q;
    rspTag_d  = rspTag_q;
    rspErr_d  = rspErr_q;
    okCnt_d   = okCnt_q;
    errCnt_d  = errCnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && rdyEn_q) begin
          coreN_d = req_n;
          tag_d   = req_tag;
          wd_d    = '0;
          state_d = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        wd_d = wd_q + WD_W'(1);
        if (capture) begin
          rspData_d = core_return;
          rspErr_d  = 1'b0;
          rspTag_d  = tag_q;
          state_d   = RESP;
        end else if (wd_q == WD_LAST) begin
          rspData_d = '0;
          rspErr_d  = 1'b1;
          rspTag_d  = tag_q;
          state_d   = RESP;
        end else if ((state_q == ISSUE) && core_ready) begin
          state_d = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          if (rspErr_q) begin
            if (errCnt_q != 8'hFF) errCnt_d = errCnt_q + 8'd1;
          end else begin
            okCnt_d = okCnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE) && rdyEn_q;
  assign core_start = (state_q == ISSUE);
  assign core_n     = coreN_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_data   = rspData_q;
  assign rsp_tag    = rspTag_q;
  assign rsp_err    = rspErr_q;
  assign ok_cnt     = okCnt_q;
  assign err_cnt    = errCnt_q;

endmodule

// File: tb/tb_fibo_req_sched.sv
// tb_fibo_req_sched
// Self-checking bench for fibo_req_sched (TIMEOUT=16). A behavioural
// fibo_fun core answers core_start with a configurable latency or hangs.
// Expected responses come from a queue of accepted requests: fib(n) for a
// good job, data 0 / err 1 for a hung one.
module tb_fibo_req_sched;

  logic        ap_clk;
  logic        ap_rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_n;
  logic [3:0]  req_tag;
  logic        core_start;
  logic [31:0] core_n;
  logic        core_ready  = 1'b0;
  logic        core_done   = 1'b0;
  logic [31:0] core_return = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic [15:0] ok_cnt;
  logic [7:0]  err_cnt;

  fibo_req_sched #(.TAG_W(4), .TIMEOUT(16)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n), .req_tag(req_tag),
    .core_start(core_start), .core_n(core_n), .core_ready(core_ready),
    .core_done(core_done), .core_return(core_return),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .ok_cnt(ok_cnt), .err_cnt(err_cnt)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  int checks = 0;
  int errors = 0;
  int okExp  = 0;
  int errExp = 0;

  // core model controls
  int          coreLat    = 0;
  bit          coreHang   = 1'b0;
  bit          manual     = 1'b0;
  bit          manReady   = 1'b0;
  bit          manDone    = 1'b0;
  bit          injectDone = 1'b0;
  logic [31:0] manRet     = 32'd0;
  bit          busy       = 1'b0;
  int          cnt        = 0;
  logic [31:0] jobN       = 32'd0;

  typedef struct {
    logic [31:0] n;
    logic [3:0]  tag;
    int          lat;
    bit          hang;
    logic [31:0] expData;
    bit          expErr;
    int          expCyc;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        err;
  } rsp_t;

  vec_t vecs[6];
  rsp_t expQ[$];

  function automatic logic [31:0] fib(input logic [31:0] n);
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd1;
    logic [31:0] t;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Behavioural fibo_fun core: accepts a start with ap_ready, returns
  // fib(n) coreLat cycles later (same cycle when coreLat is 0), or never.
  always @(negedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      busy = 1'b0;
      cnt = 0;
      core_ready = 1'b0;
      core_done = 1'b0;
      core_return = 32'd0;
    end else if (manual) begin
      core_ready = manReady;
      core_done = manDone;
      core_return = manRet;
    end else begin
      core_ready = 1'b0;
      core_done = 1'b0;
      if (injectDone) begin
        core_done = 1'b1;
        core_return = 32'hDEAD_BEEF;
      end else if (busy) begin
        if (cnt == 0) begin
          core_done = 1'b1;
          core_return = fib(jobN);
          busy = 1'b0;
        end else begin
          cnt = cnt - 1;
        end
      end else if (core_start) begin
        core_ready = 1'b1;
        jobN = core_n;
        if (!coreHang) begin
          if (coreLat == 0) begin
            core_done = 1'b1;
            core_return = fib(core_n);
          end else begin
            busy = 1'b1;
            cnt = coreLat - 1;
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic doReset;
    ap_rst = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    manual = 1'b0;
    coreHang = 1'b0;
    injectDone = 1'b0;
    tick;
    tick;
    ap_rst = 1'b0;
    okExp = 0;
    errExp = 0;
    checkOutput("readyLowBeforeEdge", req_ready, 0);
    tick;
    checkOutput("readyAfterReset", req_ready, 1);
  endtask

  // one complete job: wait for ready, issue, wait for response, handshake
  task automatic applyStimulus(input vec_t v);
    int c;
    c = 0;
    while (!req_ready && c < 50) begin tick; c++; end
    checkOutput("reqReadyWait", req_ready, 1);
    req_n = v.n;
    req_tag = v.tag;
    coreLat = v.lat;
    coreHang = v.hang;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    tick;
    req_valid = 1'b0;
    c = 0;
    while (!rsp_valid && c < 64) begin tick; c++; end
    checkOutput("rspValid", rsp_valid, 1);
    if (v.expCyc >= 0) checkOutput("latency", c, v.expCyc);
    checkOutput("rspData", rsp_data, v.expData);
    checkOutput("rspTag", rsp_tag, v.tag);
    checkOutput("rspErr", rsp_err, v.expErr);
    checkOutput("coreNHeld", core_n, v.n);
    tick;
    if (v.expErr) begin
      if (errExp < 255) errExp++;
    end else begin
      okExp++;
    end
    checkOutput("okCnt", ok_cnt, okExp);
    checkOutput("errCnt", err_cnt, errExp);
    checkOutput("rspValidDrop", rsp_valid, 0);
  endtask

  // streaming traffic against the request-queue reference model
  task automatic runTraffic(input int count, input bit randomMode);
    logic [31:0] tn[64];
    logic [3:0]  ttag[64];
    int          tlat[64];
    bit          thang[64];
    int sent, got, cyc;
    bit hsReq, hsRsp;
    rsp_t e;
    for (int i = 0; i < count; i++) begin
      tn[i] = $urandom_range(0, 40);
      ttag[i] = randomMode ? 4'($urandom) : 4'(i);
      tlat[i] = $urandom_range(0, 6);
      thang[i] = randomMode && ($urandom_range(0, 7) == 0);
    end
    sent = 0;
    got = 0;
    cyc = 0;
    while (got < count && cyc < 5000) begin
      if (sent < count) begin
        req_valid = 1'b1;
        req_n = tn[sent];
        req_tag = ttag[sent];
      end else begin
        req_valid = 1'b0;
      end
      rsp_ready = randomMode ? ($urandom_range(0, 3) != 0) : 1'b1;
      hsReq = req_valid && req_ready;
      hsRsp = rsp_valid && rsp_ready;
      if (req_ready) checkOutput("noBypass", rsp_valid, 0);
      if (hsRsp) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedRsp", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("trafData", rsp_data, e.data);
          checkOutput("trafTag", rsp_tag, e.tag);
          checkOutput("trafErr", rsp_err, e.err);
          if (e.err) begin
            if (errExp < 255) errExp++;
          end else begin
            okExp++;
          end
        end
        got++;
      end
      if (hsReq) begin
        coreLat = tlat[sent];
        coreHang = thang[sent];
        expQ.push_back('{thang[sent] ? 32'd0 : fib(tn[sent]), ttag[sent], thang[sent]});
        sent++;
      end
      tick;
      cyc++;
      if (hsRsp) begin
        checkOutput("trafOkCnt", ok_cnt, okExp);
        checkOutput("trafErrCnt", err_cnt, errExp);
      end
    end
    checkOutput("trafficDone", got, count);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    coreHang = 1'b0;
  endtask

  initial begin
    vec_t v20, vHang;
    int c;
    vecs[0] = '{32'd10, 4'd3,  5, 1'b0, 32'd55,     1'b0, -1};
    vecs[1] = '{32'd1,  4'd5,  0, 1'b0, 32'd1,      1'b0,  1};
    vecs[2] = '{32'd7,  4'd9,  0, 1'b1, 32'd0,      1'b1, 16};
    vecs[3] = '{32'd20, 4'd12, 2, 1'b0, 32'd6765,   1'b0, -1};
    vecs[4] = '{32'd0,  4'd0,  3, 1'b0, 32'd0,      1'b0, -1};
    vecs[5] = '{32'd30, 4'd15, 1, 1'b0, 32'd832040, 1'b0, -1};
    v20   = '{32'd20, 4'd7, 4, 1'b0, 32'd6765, 1'b0, -1};
    vHang = '{32'd7,  4'd1, 0, 1'b1, 32'd0,    1'b1, 16};

    ap_rst = 1'b1;
    req_valid = 1'b0;
    req_n = 32'd0;
    req_tag = 4'd0;
    rsp_ready = 1'b0;
    tick;
    tick;
    checkOutput("rstReqReady", req_ready, 0);
    checkOutput("rstCoreStart", core_start, 0);
    checkOutput("rstCoreN", core_n, 0);
    checkOutput("rstRspValid", rsp_valid, 0);
    checkOutput("rstRspData", rsp_data, 0);
    checkOutput("rstRspTag", rsp_tag, 0);
    checkOutput("rstRspErr", rsp_err, 0);
    checkOutput("rstOkCnt", ok_cnt, 0);
    checkOutput("rstErrCnt", err_cnt, 0);
    doReset;

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // core_done arrives in the very cycle the watchdog expires
    manual = 1'b1;
    manReady = 1'b0;
    manDone = 1'b0;
    manRet = 32'h1234_5678;
    req_n = 32'd5;
    req_tag = 4'hA;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    tick;
    req_valid = 1'b0;
    checkOutput("issueStart", core_start, 1);
    manReady = 1'b1;
    tick;
    manReady = 1'b0;
    checkOutput("waitNoStart", core_start, 0);
    repeat (14) tick;
    checkOutput("noEarlyExpiry", rsp_valid, 0);
    manDone = 1'b1;
    tick;
    manDone = 1'b0;
    checkOutput("doneWinsValid", rsp_valid, 1);
    checkOutput("doneWinsErr", rsp_err, 0);
    checkOutput("doneWinsData", rsp_data, 32'h1234_5678);
    checkOutput("doneWinsTag", rsp_tag, 4'hA);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    okExp++;
    checkOutput("doneWinsOkCnt", ok_cnt, okExp);
    manual = 1'b0;

    // response held by backpressure with spurious core_done
    req_n = 32'd12;
    req_tag = 4'd6;
    coreLat = 2;
    coreHang = 1'b0;
    req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    c = 0;
    while (!rsp_valid && c < 64) begin tick; c++; end
    checkOutput("bpValid", rsp_valid, 1);
    for (int i = 0; i < 20; i++) begin
      injectDone = (i >= 5 && i < 10);
      tick;
      checkOutput("bpHoldValid", rsp_valid, 1);
      checkOutput("bpHoldData", rsp_data, 32'd144);
      checkOutput("bpHoldTag", rsp_tag, 4'd6);
      checkOutput("bpHoldErr", rsp_err, 0);
      checkOutput("bpReqReady", req_ready, 0);
      checkOutput("bpOkCnt", ok_cnt, okExp);
    end
    injectDone = 1'b0;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    okExp++;
    checkOutput("releaseReady", req_ready, 1);
    checkOutput("releaseOkCnt", ok_cnt, okExp);

    // spurious core_done while idle
    injectDone = 1'b1;
    repeat (3) tick;
    injectDone = 1'b0;
    tick;
    checkOutput("idleDoneReady", req_ready, 1);
    checkOutput("idleDoneValid", rsp_valid, 0);
    checkOutput("idleDoneOkCnt", ok_cnt, okExp);
    checkOutput("idleDoneErrCnt", err_cnt, errExp);

    // asynchronous reset in the middle of WAIT
    req_n = 32'd15;
    req_tag = 4'd2;
    coreLat = 5;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    #1 ap_rst = 1'b1;
    #1;
    checkOutput("arstReqReady", req_ready, 0);
    checkOutput("arstCoreStart", core_start, 0);
    checkOutput("arstCoreN", core_n, 0);
    checkOutput("arstRspValid", rsp_valid, 0);
    checkOutput("arstRspData", rsp_data, 0);
    checkOutput("arstRspTag", rsp_tag, 0);
    checkOutput("arstRspErr", rsp_err, 0);
    checkOutput("arstOkCnt", ok_cnt, 0);
    checkOutput("arstErrCnt", err_cnt, 0);
    ap_rst = 1'b0;
    okExp = 0;
    errExp = 0;
    tick;
    checkOutput("arstReadyBack", req_ready, 1);
    for (int i = 0; i < 8; i++) begin
      tick;
      checkOutput("arstNoRsp", rsp_valid, 0);
    end
    applyStimulus(v20);

    // back-to-back requests, tags 0..7
    doReset;
    runTraffic(8, 1'b0);
    checkOutput("b2bOkCnt", ok_cnt, 16'd8);

    // 256 timeouts saturate the error counter
    for (int i = 0; i < 256; i++) applyStimulus(vHang);
    checkOutput("errCntSaturated", err_cnt, 8'd255);

    // randomized traffic with backpressure and occasional hangs
    runTraffic(60, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL globalTimeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "[TB] time limit reached");
  end

endmodule

// File: doc/fibo_req_sched.md
FIBO_REQ_SCHED -- requirements
Module: fibo_req_sched

Interface
REQ-001 Parameter TAG_W, default 4, width of the request/response tag.
REQ-002 Parameter TIMEOUT, default 1024, maximum cycles allowed from first core_start to core_done.
REQ-003 ap_clk  in  1  single clock; all state updates on rising edge.
REQ-004 ap_rst  in  1  reset, asynchronous assert, active-high.
REQ-005 req_valid  in  1  upstream request valid.
REQ-006 req_ready  out  1  request accepted when high with req_valid.
REQ-007 req_n  in  32  Fibonacci index to compute.
REQ-008 req_tag  in  TAG_W  caller tag returned with result.
REQ-009 core_start  out  1  drives ap_start of the fibo_fun core.
REQ-010 core_n  out  32  drives n of the core; stable while a job is in flight.
REQ-011 core_ready  in  1  core ap_ready.
REQ-012 core_done  in  1  core ap_done.
REQ-013 core_return  in  32  core ap_return; valid in the core_done cycle.
REQ-014 rsp_valid  out  1  response valid.
REQ-015 rsp_ready  in  1  downstream accepts response.
REQ-016 rsp_data  out  32  result, or 0 on timeout.
REQ-017 rsp_tag  out  TAG_W  tag of the originating request.
REQ-018 rsp_err  out  1  1 = timeout; 0 = good result.
REQ-019 ok_cnt  out  16  count of good responses delivered; wraps.
REQ-020 err_cnt  out  8  count of timeout responses delivered; saturates at 255.

Function
REQ-021 FSM states IDLE, ISSUE, WAIT, RESP; one job in flight at most.
REQ-022 req_ready SHALL be 1 only in IDLE; handshake in IDLE latches req_n into core_n and req_tag into the held tag, and moves to ISSUE.
REQ-023 core_start SHALL be 1 in every ISSUE cycle and 0 in all other states.
REQ-024 In ISSUE: core_ready=1 with core_done=0 -> WAIT; core_ready=1 with core_done=1 -> capture and go to RESP directly.
REQ-025 Capture: rsp_data <= core_return, rsp_err <= 0, rsp_tag <= held tag; next state RESP.
REQ-026 In WAIT: core_done=1 -> capture; core_ready ignored.
REQ-027 Watchdog counter SHALL clear on entry to ISSUE and increment each ISSUE/WAIT cycle; if it reaches TIMEOUT-1 without core_done, then rsp_data <= 0, rsp_err <= 1, next state RESP.
REQ-028 core_done in the same cycle as watchdog expiry SHALL win (good result, rsp_err=0).
REQ-029 In RESP, rsp_valid=1 and rsp_data/rsp_tag/rsp_err SHALL be stable until rsp_ready=1; then -> IDLE.
REQ-030 No bypass: req_ready SHALL rise no earlier than the cycle after the RESP handshake; minimum request-to-response latency = 2 cycles (IDLE->ISSUE, ISSUE->RESP).
REQ-031 ok_cnt increments on each RESP handshake with rsp_err=0 (wrap 0xFFFF->0); err_cnt increments on each with rsp_err=1 (hold at 0xFF).
REQ-032 core_done or core_ready in IDLE or RESP SHALL be ignored, with no state or counter change.
REQ-033 core_n SHALL hold the last accepted req_n in all states until the next request is accepted.

Reset
REQ-034 While ap_rst=1: state=IDLE, req_ready=0, core_start=0, core_n=0, rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_err=0, ok_cnt=0, err_cnt=0, watchdog=0.
REQ-035 req_ready SHALL go to 1 in the first clock edge after ap_rst deasserts.
REQ-036 Reset during ISSUE/WAIT/RESP SHALL abort the job with no response emitted and counters cleared.

Verification
REQ-037 Core model fib(0)=0, fib(1)=1, 5-cycle latency: req_n=10, tag=3 -> rsp_data=55, rsp_tag=3, rsp_err=0, ok_cnt=1.
REQ-038 Core asserts core_ready and core_done in the same cycle (n=1) -> RESP next cycle, rsp_data=1; latency 2 cycles from handshake.
REQ-039 TIMEOUT=16, core never asserts done -> rsp_valid on cycle 16 after ISSUE entry, rsp_data=0, rsp_err=1, err_cnt=1; then 256 timeouts -> err_cnt=255.
REQ-040 rsp_ready held low 20 cycles in RESP -> outputs stable, req_ready=0, spurious core_done ignored; release -> req_ready=1 the next cycle.
REQ-041 ap_rst pulsed mid-WAIT -> all outputs 0 immediately (asynchronous), no response, next request n=20 -> rsp_data=6765.
REQ-042 Back-to-back requests (req_valid held, tags 0..7) -> 8 in-order responses with matching tags, ok_cnt=8.
